// File: rtl/ioctl_sink_pkg.sv
// Shared types and constants for the ioctl ROM download sink.
package ioctl_sink_pkg;

  localparam int unsigned ROM_INDEX_MAX = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } sink_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } fifo_entry_t;

  // Running high-water mark of the loaded image; addr + 2 wraps at 25 bits.
  function automatic logic [24:0] size_max(logic [24:0] cur, logic [24:0] addr);
    logic [24:0] cand;
    cand = addr + 25'd2;
    return (cand > cur) ? cand : cur;
  endfunction

endpackage

// File: rtl/ioctl_rom_sink_if.sv
// ioctl download stream plus SDRAM write request/acknowledge port.
interface ioctl_rom_sink_if #(
  parameter int unsigned AW = 25
);
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [15:0]   ioctl_dout;
  logic          ioctl_wait;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ack;

  // Environment view: drives the download stream and answers memory requests.
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    input  ioctl_wait, mem_req, mem_addr, mem_wdata
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    output ioctl_wait, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_sys) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ioctl_rom_sink.sv
// Buffers HPS ioctl ROM download words and replays them as SDRAM writes.
// Optional IOCTL_SINK_CKSUM_EN adds a 16-bit running sum of accepted words.
module ioctl_rom_sink
  import ioctl_sink_pkg::*;
#(
  parameter int unsigned   DEPTH     = 4,
  parameter int unsigned   AW        = 25,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int unsigned   INDEX_MAX = ROM_INDEX_MAX
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  ioctl_rom_sink_if.slave        bus,
  output logic                   busy,
  output logic                   done,
  output logic [24:0]            rom_size,
  output logic                   overflow
`ifdef IOCTL_SINK_CKSUM_EN
  ,
  output logic [15:0]            cksum
`endif
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  sink_state_t   state_q;
  logic          dl_q;
  logic          req_q, wait_q, done_q, ovf_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q;
  logic [24:0]   size_q;

  fifo_entry_t   push_entry, head_entry, issue_entry;
  logic [$bits(fifo_entry_t)-1:0] head_raw;
  logic [CW-1:0] count, count_next;
  logic          full, empty, push, pop, fifo_clr;
  logic          dl_rise, dl_fall, idx_ok, wr_load;
  logic          unused_index;

  assign unused_index = ^bus.ioctl_index[7:6];
  assign idx_ok   = 32'(bus.ioctl_index[5:0]) <= INDEX_MAX;
  assign dl_rise  = bus.ioctl_download & ~dl_q;
  assign dl_fall  = ~bus.ioctl_download & dl_q;
  assign wr_load  = (state_q == LOAD) & bus.ioctl_wr;
  assign push     = wr_load & ~full;
  assign pop      = req_q & bus.mem_ack;
  assign fifo_clr = (state_q == IDLE) & dl_rise & idx_ok;

  assign push_entry  = '{addr: bus.ioctl_addr, data: bus.ioctl_dout};
  assign head_entry  = head_raw;
  // An empty FIFO forwards the incoming word so a request rises one cycle after the strobe.
  assign issue_entry = empty ? push_entry : head_entry;
  assign count_next  = count + CW'(push) - CW'(pop);

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (fifo_clr),
    .push    (push),
    .wdata   (push_entry),
    .pop     (pop),
    .rdata   (head_raw),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

`ifdef IOCTL_SINK_CKSUM_EN
  logic [15:0] cksum_q;
  assign cksum = cksum_q;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dl_q    <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      size_q  <= '0;
`ifdef IOCTL_SINK_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      dl_q   <= bus.ioctl_download;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fifo_clr) begin
            state_q <= LOAD;
            size_q  <= '0;
            ovf_q   <= 1'b0;
`ifdef IOCTL_SINK_CKSUM_EN
            cksum_q <= '0;
`endif
          end
        end
        LOAD: begin
          if (wr_load) begin
            size_q <= size_max(size_q, bus.ioctl_addr);
            if (full) ovf_q <= 1'b1;
          end
`ifdef IOCTL_SINK_CKSUM_EN
          if (push) cksum_q <= cksum_q + bus.ioctl_dout;
`endif
          if (dl_fall) state_q <= FLUSH;
        end
        FLUSH: begin
          if (empty && !req_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // The entry stays in the FIFO until acknowledged; a low cycle always follows each ack.
      if (pop) begin
        req_q <= 1'b0;
      end else if (!req_q && (!empty || push)) begin
        req_q   <= 1'b1;
        addr_q  <= BASE_ADDR + AW'(issue_entry.addr);
        wdata_q <= issue_entry.data;
      end

      wait_q <= (state_q == LOAD) && !dl_fall && (count_next >= CW'(DEPTH - 1));
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.mem_req    = req_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign rom_size       = size_q;
  assign overflow       = ovf_q;

endmodule
